// File: rtl/audio_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_stream_pkg
// Description : Shared definitions for the transmit-side audio stream path:
//               default widths/depths and the packet FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package audio_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Packet FSM state encoding. SEND_RIGHT differs from SEND_LEFT in bit 1 only,
  // so bit 1 alone tells whether the right (last) beat is on the bus.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'b00;
  localparam state_t ST_SEND_LEFT  = 2'b01;
  localparam state_t ST_SEND_RIGHT = 2'b11;

endpackage : audio_stream_pkg
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous first-word-fall-through FIFO for mono samples.
//               rd_data always presents the head entry while !empty.
// Ports       : clk, rst_n          - clock, async active-low reset
//               wr_en, wr_data      - push request and data (ignored when full)
//               rd_en, rd_data      - pop request (ignored when empty), head data
//               full, empty, level  - occupancy status from the registered count
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
  import audio_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0]  PTR_ONE    = ADDR_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q,  level_d;

  logic do_wr;
  logic do_rd;

  // Requests are qualified internally so a stray push on full or pop on empty
  // can never corrupt the pointers or the count.
  always_comb begin
    do_wr    = wr_en && (level_q != FULL_LEVEL);
    do_rd    = rd_en && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves the count unchanged.
    unique case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign level   = level_q;

endmodule : sample_fifo
`default_nettype wire

// File: rtl/mono_to_packet_sample_converter.sv
`default_nettype none
// ============================================================================
// Module      : mono_to_packet_sample_converter
// Description : Accepts mono samples on a valid/ready handshake, queues them in
//               a small FIFO and emits each as a two-beat stereo AXI-Stream
//               packet (left beat, then right beat with TLAST). Both beats
//               carry the same sample unmodified.
// Ports       : M_AXIS_ACLK, M_AXIS_ARESETN - clock, async active-low reset
//               sample_in/sample_valid/sample_ready - mono sample input
//               M_AXIS_TVALID/TDATA/TLAST/TREADY    - stereo packet output
//               fifo_level                          - queued sample count
// Revision    : 1.0 - initial release
// ============================================================================
module mono_to_packet_sample_converter
  import audio_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          M_AXIS_ACLK,
  input  logic                          M_AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0]         sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  // Set on the first edge after reset release; holds sample_ready low while
  // reset is asserted even though the (empty) FIFO would accept.
  logic                  running_q, running_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_sample_fifo (
    .clk     (M_AXIS_ACLK),
    .rst_n   (M_AXIS_ARESETN),
    .wr_en   (fifo_push),
    .wr_data (sample_in),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      running_q <= running_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_SEND_LEFT;
        end
      end
      ST_SEND_LEFT: begin
        if (M_AXIS_TREADY) begin
          state_d = ST_SEND_RIGHT;
        end
      end
      ST_SEND_RIGHT: begin
        // Chain straight into the next packet when one is queued so that a
        // continuously ready sink sees no idle beat between packets.
        if (M_AXIS_TREADY) begin
          state_d = fifo_empty ? ST_IDLE : ST_SEND_LEFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    running_d = 1'b1;

    // A sample leaves the FIFO only when a new packet is loaded: from Idle,
    // or as the right beat of the current packet is accepted.
    fifo_pop = !fifo_empty &&
               ((state_q == ST_IDLE) ||
                ((state_q == ST_SEND_RIGHT) && M_AXIS_TREADY));

    data_d = fifo_pop ? fifo_rd_data : data_q;

    // Depends only on registered state: the FIFO count and running_q.
    sample_ready = running_q && !fifo_full;
    fifo_push    = sample_valid && sample_ready;

    M_AXIS_TVALID = (state_q != ST_IDLE);
    M_AXIS_TLAST  = (state_q == ST_SEND_RIGHT);
    M_AXIS_TDATA  = data_q;
  end

endmodule : mono_to_packet_sample_converter
`default_nettype wire
